// File: rtl/xor_link_pkg.sv
// Shared constants and types for the serial XOR-cipher link.
package xor_link_pkg;

    localparam int MSG_SIZE_DEF = 64;
    localparam int KEY_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DECRYPT = 2'd2
    } state_t;

    // Bit counters hold 0..n, so they need one bit more than clog2(n).
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/serial_shift_in.sv
// MSB-first serial-to-parallel shifter with a bit counter that clears on the last bit.
module serial_shift_in #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             serial_in,
    input  logic             clear,
    output logic [WIDTH-1:0] parallel_out,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    assign done = shift_en && !clear && (count == CNT_W'(WIDTH - 1));

    // clear together with shift_en restarts the register with the incoming bit as bit 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parallel_out <= '0;
            count        <= '0;
        end else if (clear) begin
            if (shift_en) begin
                parallel_out <= {{(WIDTH-1){1'b0}}, serial_in};
                count        <= CNT_W'(1);
            end else begin
                parallel_out <= '0;
                count        <= '0;
            end
        end else if (shift_en) begin
            parallel_out <= {parallel_out[WIDTH-2:0], serial_in};
            count        <= done ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/xor_decrypt_receiver.sv
// Far-end receiver: serial key load, serial ciphertext capture, repeating-key XOR decrypt,
// plaintext presented under oValid/iAck.
module xor_decrypt_receiver
    import xor_link_pkg::*;
#(
    parameter int MSG_SIZE = MSG_SIZE_DEF,
    parameter int KEY_SIZE = KEY_SIZE_DEF
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          iEn,
    input  logic                          iKey_serial,
    input  logic                          iLoad_key,
    input  logic                          iSerial_in,
    input  logic                          iSerial_flag,
    input  logic                          iAck,
    output logic [MSG_SIZE-1:0]           oPlaintext,
    output logic                          oValid,
    output logic                          oKey_ready,
    output logic                          oBusy,
    output logic                          oFrame_error,
    output logic                          oOverrun,
    output state_t                        oState,
    output logic [cnt_width(MSG_SIZE)-1:0] oBit_count
);

    localparam int KCW = cnt_width(KEY_SIZE);
    localparam int MCW = cnt_width(MSG_SIZE);

    logic [KEY_SIZE-1:0] key_vec;
    logic [KCW-1:0]      key_cnt;
    logic                key_done;
    logic                key_shift;
    logic                key_ok;

    logic [MSG_SIZE-1:0] msg_vec;
    logic                msg_done;
    logic                msg_shift;
    logic                msg_clear;
    logic                drop_r;
    logic [MSG_SIZE-1:0] plain_next;

    assign key_shift = iEn && iLoad_key;
    // A frame is accepted only against a complete, stable key.
    assign key_ok    = oKey_ready && (key_cnt == '0) && !iLoad_key;

    serial_shift_in #(.WIDTH(KEY_SIZE), .CNT_W(KCW)) u_key (
        .clk          (iClk),
        .rst          (iRst),
        .shift_en     (key_shift),
        .serial_in    (iKey_serial),
        .clear        (1'b0),
        .parallel_out (key_vec),
        .count        (key_cnt),
        .done         (key_done)
    );

    serial_shift_in #(.WIDTH(MSG_SIZE), .CNT_W(MCW)) u_msg (
        .clk          (iClk),
        .rst          (iRst),
        .shift_en     (msg_shift),
        .serial_in    (iSerial_in),
        .clear        (msg_clear),
        .parallel_out (msg_vec),
        .count        (oBit_count),
        .done         (msg_done)
    );

    always_comb begin
        msg_shift = 1'b0;
        msg_clear = 1'b0;
        if (iEn) begin
            case (oState)
                IDLE: if (!drop_r && iSerial_flag && key_ok) begin
                    msg_clear = 1'b1;
                    msg_shift = 1'b1;
                end
                RECV: if (iSerial_flag) msg_shift = 1'b1;
                      else              msg_clear = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        plain_next = '0;
        for (int i = 0; i < MSG_SIZE; i++)
            plain_next[i] = msg_vec[i] ^ key_vec[i % KEY_SIZE];
    end

    // oValid rises with oPlaintext and holds until a cycle with iAck=1; a DECRYPT write
    // in that same cycle replaces the frame and keeps oValid high.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oState       <= IDLE;
            drop_r       <= 1'b0;
            oPlaintext   <= '0;
            oValid       <= 1'b0;
            oKey_ready   <= 1'b0;
            oBusy        <= 1'b0;
            oFrame_error <= 1'b0;
            oOverrun     <= 1'b0;
        end else if (iEn) begin
            oFrame_error <= 1'b0;
            if (iLoad_key) oKey_ready <= key_done;
            if (oValid && iAck) oValid <= 1'b0;
            case (oState)
                IDLE: begin
                    if (drop_r) begin
                        if (!iSerial_flag) drop_r <= 1'b0;
                    end else if (iSerial_flag) begin
                        if (key_ok) begin
                            oState <= RECV;
                            oBusy  <= 1'b1;
                        end else begin
                            oFrame_error <= 1'b1;
                            drop_r       <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (!iSerial_flag) begin
                        oState       <= IDLE;
                        oBusy        <= 1'b0;
                        oFrame_error <= 1'b1;
                    end else if (msg_done) begin
                        oState <= DECRYPT;
                        oBusy  <= 1'b0;
                    end
                end
                DECRYPT: begin
                    if (!oValid || iAck) begin
                        oPlaintext <= plain_next;
                        oValid     <= 1'b1;
                    end else begin
                        oOverrun <= 1'b1;
                    end
                    oState <= IDLE;
                end
                default: oState <= IDLE;
            endcase
        end
    end

endmodule
